// File: rtl/bcd_serial_addsub.sv
// bcd_serial_addsub: digit-serial BCD adder/subtractor.
// Operands arrive least significant digit first, one digit pair per accepted
// cycle. Subtraction adds the nine's complement of B and seeds the carry with 1,
// so a final carry of 1 means A >= B.
//
// Handshake: a digit pair is consumed on every rising edge where
// valid_in && ready. ready is high only in RUN. Each consumed pair yields
// exactly one valid_out pulse on the next cycle. valid_in is never back-pressured
// inside RUN.
//
// Timing: the last result digit appears in the DONE cycle. done and cout are
// registered off DONE, so they appear one cycle later, in the first IDLE cycle.
//
// Optional feature: define BCD_SERIAL_ADDSUB_CHECK_EN to flag non-BCD input
// digits on err. err is sticky until the next start.
// In that build a non-BCD B digit is complemented as 15-b when subtracting.
module bcd_serial_addsub #(
    parameter int DIGITS = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       sub,
    input  logic       valid_in,
    input  logic [3:0] a3_a0,
    input  logic [3:0] b3_b0,
    output logic       ready,
    output logic [3:0] s3_s0,
    output logic       valid_out,
    output logic       done,
    output logic       cout,
    output logic       err,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [4:0] LAST = 5'(DIGITS - 1);

    state_t     state_q, state_d;
    logic [4:0] count_q;
    logic       carry_q;
    logic       sub_q;
    logic       accept;
    logic       last_pair;
    logic [3:0] b_eff;
    logic [4:0] raw_sum;
    logic [3:0] digit_d;
    logic       carry_d;

    assign accept    = (state_q == RUN) && valid_in;
    assign last_pair = (count_q == LAST);
    assign ready     = (state_q == RUN);
    assign state_dbg = state_q;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. start is ignored outside IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (accept && last_pair) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Digit adder. b_eff is the complemented B digit when subtracting.
    // Any raw sum above 9 is corrected by +6 and produces a carry.
    always_comb begin
        b_eff = b3_b0;
        if (sub_q) begin
`ifdef BCD_SERIAL_ADDSUB_CHECK_EN
            b_eff = (b3_b0 > 4'd9) ? (4'd15 - b3_b0) : (4'd9 - b3_b0);
`else
            b_eff = 4'd9 - b3_b0;
`endif
        end
        raw_sum = {1'b0, a3_a0} + {1'b0, b_eff} + {4'b0000, carry_q};
        digit_d = raw_sum[3:0];
        carry_d = 1'b0;
        if (raw_sum > 5'd9) begin
            digit_d = raw_sum[3:0] + 4'd6;
            carry_d = 1'b1;
        end
    end

    // Datapath registers: operation, carry, digit counter and result outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sub_q     <= 1'b0;
            carry_q   <= 1'b0;
            count_q   <= 5'd0;
            s3_s0     <= 4'd0;
            valid_out <= 1'b0;
            done      <= 1'b0;
            cout      <= 1'b0;
        end else begin
            valid_out <= accept;
            done      <= (state_q == DONE);
            if ((state_q == IDLE) && start) begin
                sub_q   <= sub;
                carry_q <= sub;
                count_q <= 5'd0;
                cout    <= 1'b0;
            end
            if (accept) begin
                s3_s0   <= digit_d;
                carry_q <= carry_d;
                count_q <= count_q + 5'd1;
            end
            if (state_q == DONE) begin
                cout <= carry_q;
            end
        end
    end

`ifdef BCD_SERIAL_ADDSUB_CHECK_EN
    logic digit_bad;
    assign digit_bad = (a3_a0 > 4'd9) || (b3_b0 > 4'd9);

    // Sticky flag for non-BCD input digits. Cleared at start.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if ((state_q == IDLE) && start) begin
            err <= 1'b0;
        end else if (accept && digit_bad) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Directed testbench for bcd_serial_addsub (DIGITS = 4).
// The expected digits are computed by hand from the decimal operands.
module tb_bcd_serial_addsub;

    logic       clock;
    logic       reset;
    logic       start;
    logic       sub;
    logic       valid_in;
    logic [3:0] a3_a0;
    logic [3:0] b3_b0;
    logic       ready;
    logic [3:0] s3_s0;
    logic       valid_out;
    logic       done;
    logic       cout;
    logic       err;
    logic [1:0] state_dbg;

    int checks   = 0;
    int failures = 0;

    bcd_serial_addsub #(.DIGITS(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .sub       (sub),
        .valid_in  (valid_in),
        .a3_a0     (a3_a0),
        .b3_b0     (b3_b0),
        .ready     (ready),
        .s3_s0     (s3_s0),
        .valid_out (valid_out),
        .done      (done),
        .cout      (cout),
        .err       (err),
        .state_dbg (state_dbg)
    );

    // Clock generator.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete operation.
    // gap: the number of idle cycles inserted between digit pairs.
    // chk_digits = 0 skips checking the digit values.
    task automatic run_op(input string tag, input logic op_sub,
                          input logic [15:0] a, input logic [15:0] b,
                          input int gap, input logic [15:0] exp_s,
                          input logic exp_cout, input logic exp_err,
                          input logic chk_digits);
        logic [3:0] last_digit;
        @(negedge clock);
        start = 1'b1;
        sub   = op_sub;
        @(negedge clock);
        start = 1'b0;
        sub   = 1'b0;
        check({tag, "_ready_run"}, 16'(ready), 16'd1);
        check({tag, "_err_clr"}, 16'(err), 16'd0);
        check({tag, "_cout_clr"}, 16'(cout), 16'd0);
        for (int i = 0; i < 4; i++) begin
            valid_in = 1'b1;
            a3_a0    = a[4*i +: 4];
            b3_b0    = b[4*i +: 4];
            @(negedge clock);
            valid_in = 1'b0;
            last_digit = s3_s0;
            check($sformatf("%s_vout%0d", tag, i), 16'(valid_out), 16'd1);
            if (chk_digits)
                check($sformatf("%s_dig%0d", tag, i), 16'(s3_s0), 16'(exp_s[4*i +: 4]));
            check($sformatf("%s_rdy%0d", tag, i), 16'(ready), (i < 3) ? 16'd1 : 16'd0);
            if (i < 3) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clock);
                    check($sformatf("%s_gap_vout%0d_%0d", tag, i, g), 16'(valid_out), 16'd0);
                    check($sformatf("%s_gap_hold%0d_%0d", tag, i, g), 16'(s3_s0), 16'(last_digit));
                end
            end
        end
        check({tag, "_done_early"}, 16'(done), 16'd0);
        @(negedge clock);
        check({tag, "_done"}, 16'(done), 16'd1);
        check({tag, "_cout"}, 16'(cout), 16'(exp_cout));
        check({tag, "_err"}, 16'(err), 16'(exp_err));
        check({tag, "_vout_end"}, 16'(valid_out), 16'd0);
        check({tag, "_hold_end"}, 16'(s3_s0), 16'(last_digit));
        @(negedge clock);
        check({tag, "_done_pulse"}, 16'(done), 16'd0);
        check({tag, "_cout_hold"}, 16'(cout), 16'(exp_cout));
        check({tag, "_state_idle"}, 16'(state_dbg), 16'd0);
    endtask

    initial begin
        logic exp_chk_err;
`ifdef BCD_SERIAL_ADDSUB_CHECK_EN
        exp_chk_err = 1'b1;
`else
        exp_chk_err = 1'b0;
`endif
        reset    = 1'b1;
        start    = 1'b0;
        sub      = 1'b0;
        valid_in = 1'b0;
        a3_a0    = 4'd0;
        b3_b0    = 4'd0;
        repeat (2) @(negedge clock);
        check("rst_ready", 16'(ready), 16'd0);
        check("rst_vout", 16'(valid_out), 16'd0);
        check("rst_done", 16'(done), 16'd0);
        check("rst_s", 16'(s3_s0), 16'd0);
        check("rst_cout", 16'(cout), 16'd0);
        check("rst_err", 16'(err), 16'd0);
        check("rst_state", 16'(state_dbg), 16'd0);
        reset = 1'b0;

        // The result digits are listed most significant first, in packed BCD.
        run_op("add_1234_5678", 1'b0, 16'h1234, 16'h5678, 0, 16'h6912, 1'b0, 1'b0, 1'b1);
        run_op("add_9999_0001", 1'b0, 16'h9999, 16'h0001, 0, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_op("sub_5000_1234", 1'b1, 16'h5000, 16'h1234, 0, 16'h3766, 1'b1, 1'b0, 1'b1);
        run_op("sub_0012_0020", 1'b1, 16'h0012, 16'h0020, 0, 16'h9992, 1'b0, 1'b0, 1'b1);
        run_op("sub_1234_gap", 1'b1, 16'h1234, 16'h1234, 2, 16'h0000, 1'b1, 1'b0, 1'b1);

        // valid_in while IDLE must be ignored.
        @(negedge clock);
        valid_in = 1'b1;
        a3_a0    = 4'd5;
        b3_b0    = 4'd3;
        @(negedge clock);
        valid_in = 1'b0;
        check("idle_vin_vout", 16'(valid_out), 16'd0);
        check("idle_vin_hold", 16'(s3_s0), 16'd0);
        check("idle_vin_ready", 16'(ready), 16'd0);

        // Reset mid-operation, after two accepted pairs.
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            valid_in = 1'b1;
            a3_a0    = 4'd7;
            b3_b0    = 4'd1;
            @(negedge clock);
        end
        valid_in = 1'b0;
        check("mid_vout", 16'(valid_out), 16'd1);
        check("mid_s", 16'(s3_s0), 16'd8);
        reset = 1'b1;
        #1;
        check("mid_rst_ready", 16'(ready), 16'd0);
        check("mid_rst_vout", 16'(valid_out), 16'd0);
        check("mid_rst_done", 16'(done), 16'd0);
        check("mid_rst_s", 16'(s3_s0), 16'd0);
        check("mid_rst_cout", 16'(cout), 16'd0);
        check("mid_rst_err", 16'(err), 16'd0);
        check("mid_rst_state", 16'(state_dbg), 16'd0);
        @(negedge clock);
        reset = 1'b0;
        run_op("add_0001_0002", 1'b0, 16'h0001, 16'h0002, 0, 16'h0003, 1'b0, 1'b0, 1'b1);

        // Non-BCD digit in position 1. err is 1 only in the checking build.
        // In that build the digits follow the raw-sum rule: 0, 0 (10 with carry), 1, 0.
        run_op("bad_digit", 1'b0, 16'h00A0, 16'h0000, 0, 16'h0100, 1'b0, exp_chk_err, exp_chk_err);
        run_op("after_bad", 1'b0, 16'h0005, 16'h0004, 0, 16'h0009, 1'b0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_serial_addsub.md
BCD_SERIAL_ADDSUB -- requirements
Module: bcd_serial_addsub

Interface
REQ-001 Parameter DIGITS, default 4, SHALL set the operand length in decimal digits (range 1..16).
REQ-002 clock  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-004 start  input  1  SHALL begin an operation when sampled high in IDLE.
REQ-005 sub  input  1  SHALL select the operation, sampled with start: 0 = A+B, 1 = A-B.
REQ-006 valid_in  input  1  SHALL qualify the a3_a0/b3_b0 digit pair.
REQ-007 a3_a0  input  4  SHALL carry the BCD digit of A, least significant first.
REQ-008 b3_b0  input  4  SHALL carry the BCD digit of B, least significant first.
REQ-009 ready  output  1  SHALL be high while the block accepts digit pairs (state RUN).
REQ-010 s3_s0  output  4  SHALL carry the registered BCD result digit.
REQ-011 valid_out  output  1  SHALL qualify s3_s0 for exactly one cycle per accepted pair.
REQ-012 done  output  1  SHALL pulse high for one cycle after the last result digit.
REQ-013 cout  output  1  SHALL hold the final decimal carry from done until the next start.
REQ-014 err  output  1  SHALL flag an invalid BCD input digit (see Configuration).

Function
REQ-015 FSM states SHALL be IDLE, RUN, DONE; reset SHALL enter IDLE.
REQ-016 IDLE -> RUN on start=1; carry register SHALL load sub, the operation register SHALL latch sub, the digit counter SHALL clear, cout and err SHALL clear.
REQ-017 In RUN, a pair SHALL be accepted on each cycle with valid_in=1 and ready=1; cycles with valid_in=0 SHALL leave all state unchanged.
REQ-018 Operand b' SHALL be b3_b0 when adding and its nine's complement (9-b) when subtracting.
REQ-019 Raw sum t = a + b' + carry (5 bits); if t > 9 the digit SHALL be t+6 truncated to 4 bits (equivalently t-10) and the new carry SHALL be 1, else the digit SHALL be t and the carry 0.
REQ-020 Result digit SHALL appear on s3_s0 with valid_out=1 in the cycle after acceptance (latency 1).
REQ-021 After the DIGITS-th accepted pair, the FSM SHALL go to DONE and ready SHALL drop in the following cycle.
REQ-022 DONE SHALL last one cycle with done=1, cout = final carry, and the FSM SHALL then return to IDLE.
REQ-023 For subtraction, cout=1 SHALL mean A>=B (result is A-B); cout=0 SHALL mean A<B (result is the ten's complement of B-A).
REQ-024 For addition, cout=1 SHALL mean decimal overflow.
REQ-025 start outside IDLE and valid_in outside RUN SHALL be ignored.
REQ-026 s3_s0 SHALL hold its last value when valid_out=0.

Reset
REQ-027 Asserting reset SHALL, at any time (including mid-operation), force: FSM IDLE, ready=0, valid_out=0, done=0, s3_s0=0, cout=0, err=0, carry=0, counter=0.
REQ-028 The first rising edge after reset deasserts SHALL behave as an IDLE cycle.

Configuration
REQ-029 Macro BCD_SERIAL_ADDSUB_CHECK_EN SHALL control input digit checking.
REQ-030 When defined, any accepted digit a or b > 9 SHALL set err, sticky until the next start or reset; the computation SHALL proceed per REQ-019 with b' = 15-b when subtracting.
REQ-031 When undefined, err SHALL be tied to 0, and results for non-BCD inputs SHALL be unspecified.

Verification
REQ-032 DIGITS=4, add 1234+5678, one pair per cycle -> s digits 2,1,9,6 (LSD first) on consecutive cycles, done on next cycle, cout=0.
REQ-033 Add 9999+0001 -> digits 0,0,0,0, cout=1.
REQ-034 Sub 5000-1234 -> digits 6,6,7,3, cout=1; sub 0012-0020 -> digits 2,9,9,9, cout=0.
REQ-035 Sub 1234-1234 with valid_in held low for 2 cycles between each pair -> digits 0,0,0,0, cout=1, valid_out count 4, no output during gaps.
REQ-036 Reset asserted after 2 accepted pairs -> all outputs 0 immediately; next start with add 0001+0002 -> 3,0,0,0, cout=0.
REQ-037 With BCD_SERIAL_ADDSUB_CHECK_EN defined, a=0xA in digit 1 -> err=1 through done; cleared by next start; undefined -> err=0.
